// File: rtl/sub_16la_pipe.sv
// sub_16la_pipe: 16-bit subtractor (diff = a - b - bin) built from four
// 4-bit borrow-lookahead slices. The pipeline has four stages and one slice
// per stage. It uses a valid/ready handshake and can stall as a whole.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   a, b, bin             minuend, subtrahend, borrow-in
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   diff, bout            result mod 2^16, borrow-out of bit 15
//   zero, ovf             diff == 0, signed overflow (registered)
//   out_valid / out_ready result handshake

module sub_16la_pipe (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic        zero,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    // One 4-bit slice. All borrows come from g/p and the slice borrow-in
    // in a single sum-of-products level. There is no ripple inside the slice.
    // Returns {borrow_out, d[3:0]}.
    function automatic logic [4:0] la_sub4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = ~x & y;
        p    = ~(x ^ y);
        c[0] = c0;
        c[1] = g[0]
             | (p[0] & c0);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c0);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], x ^ y ^ c[3:0]};
    endfunction

    // Stage 0: operands as accepted
    logic        r_v0;
    logic [15:0] r_a0;
    logic [15:0] r_b0;
    logic        r_bin0;

    // Stage 1: slice 0 done, slices 1..3 still pending
    logic        r_v1;
    logic [15:4] r_a1;
    logic [15:4] r_b1;
    logic [3:0]  r_d1;
    logic        r_br1;

    // Stage 2: slices 0..1 done
    logic        r_v2;
    logic [15:8] r_a2;
    logic [15:8] r_b2;
    logic [7:0]  r_d2;
    logic        r_br2;

    // Stage 3: slices 0..2 done
    logic        r_v3;
    logic [15:12] r_a3;
    logic [15:12] r_b3;
    logic [11:0] r_d3;
    logic        r_br3;

    // Output register
    logic        r_out_valid;
    logic [15:0] r_diff;
    logic        r_bout;
    logic        r_zero;
    logic        r_ovf;

    logic        w_en;
    logic [4:0]  w_s0;
    logic [4:0]  w_s1;
    logic [4:0]  w_s2;
    logic [4:0]  w_s3;
    logic [15:0] w_diff;
    logic        w_ovf;

    // The whole pipe moves together. It freezes only while a result is
    // waiting and downstream refuses it.
    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en;

    assign w_s0 = la_sub4(r_a0[3:0],     r_b0[3:0],     r_bin0);
    assign w_s1 = la_sub4(r_a1[7:4],     r_b1[7:4],     r_br1);
    assign w_s2 = la_sub4(r_a2[11:8],    r_b2[11:8],    r_br2);
    assign w_s3 = la_sub4(r_a3[15:12],   r_b3[15:12],   r_br3);

    assign w_diff = {w_s3[3:0], r_d3};
    assign w_ovf  = (r_a3[15] ^ r_b3[15]) & (r_a3[15] ^ w_diff[15]);

    // Stage 0 captures operands only on an accepted handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v0   <= 1'b0;
            r_a0   <= '0;
            r_b0   <= '0;
            r_bin0 <= 1'b0;
        end else if (w_en) begin
            r_v0 <= in_valid;
            if (in_valid) begin
                r_a0   <= a;
                r_b0   <= b;
                r_bin0 <= bin;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1  <= 1'b0;
            r_a1  <= '0;
            r_b1  <= '0;
            r_d1  <= '0;
            r_br1 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_a1  <= r_a0[15:4];
                r_b1  <= r_b0[15:4];
                r_d1  <= w_s0[3:0];
                r_br1 <= w_s0[4];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v2  <= 1'b0;
            r_a2  <= '0;
            r_b2  <= '0;
            r_d2  <= '0;
            r_br2 <= 1'b0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_a2  <= r_a1[15:8];
                r_b2  <= r_b1[15:8];
                r_d2  <= {w_s1[3:0], r_d1};
                r_br2 <= w_s1[4];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v3  <= 1'b0;
            r_a3  <= '0;
            r_b3  <= '0;
            r_d3  <= '0;
            r_br3 <= 1'b0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_a3  <= r_a2[15:12];
                r_b3  <= r_b2[15:12];
                r_d3  <= {w_s2[3:0], r_d2};
                r_br3 <= w_s2[4];
            end
        end
    end

    // Bubbles clear out_valid but leave the last result in place.
    // Flags are computed here, so the outputs have no logic after the register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_v3;
            if (r_v3) begin
                r_diff <= w_diff;
                r_bout <= w_s3[4];
                r_zero <= (w_diff == 16'h0000);
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule
